// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I sequencing controller.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEMADR    = 4'd2,
    S_MEMREAD   = 4'd3,
    S_MEMWB     = 4'd4,
    S_MEMWRITE  = 4'd5,
    S_EXECR     = 4'd6,
    S_EXECI     = 4'd7,
    S_ALUWB     = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_JALR_ADR  = 4'd11,
    S_LUI       = 4'd12,
    S_AUIPC     = 4'd13,
    S_ILLEGAL   = 4'd14
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_IMMEXT    = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // lb/lh/lw/lbu/lhu only
  function automatic logic load_f3_legal(logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
           (f3 == 3'b100) || (f3 == 3'b101);
  endfunction

  // sb/sh/sw only
  function automatic logic store_f3_legal(logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
  endfunction

endpackage

// File: rtl/mc_perf_cnt.sv
// Wrapping cycle / retired-instruction / memory-stall counters.
// Only built when MC_CTRL_PERF_EN is defined.
`ifdef MC_CTRL_PERF_EN
module mc_perf_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instret_inc,
  input  logic             stall_inc,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (instret_inc) instret_cnt <= instret_cnt + CNT_W'(1);
      if (stall_inc)   stall_cnt   <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
`endif

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencing FSM driving the shared datapath and unified memory port.
// Optional performance counters under MC_CTRL_PERF_EN.
module multicycle_ctrl
  import mc_ctrl_pkg::*;
`ifdef MC_CTRL_PERF_EN
#(
  parameter int unsigned CNT_W = 32
)
`endif
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [2:0] imm_src,
  output logic [2:0] data_src,
  output logic       illegal
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  state_t state, state_next;
  logic   mem_req_c, mem_write_c, ir_write_c, pc_write_c, reg_write_c, illegal_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_next;
  end

  // Load width/sign select captured while the instruction is being decoded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  data_src <= '0;
    else if (state == S_DECODE)  data_src <= funct3;
  end

  always_comb begin
    state_next  = state;
    mem_req_c   = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    reg_write_c = 1'b0;
    illegal_c   = 1'b0;
    adr_src     = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RD2;
    alu_op      = ALU_ADD;
    imm_src     = IMM_I;

    case (state)
      S_FETCH: begin
        mem_req_c  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        // ALUOut picks up OldPC + imm; the immediate type depends on which target is needed.
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        if (op == OP_JAL)                         imm_src = IMM_J;
        else if ((op == OP_LUI) || (op == OP_AUIPC)) imm_src = IMM_U;
        else                                      imm_src = IMM_B;
        case (op)
          OP_LOAD:   state_next = load_f3_legal(funct3)  ? S_MEMADR : S_ILLEGAL;
          OP_STORE:  state_next = store_f3_legal(funct3) ? S_MEMADR : S_ILLEGAL;
          OP_R:      state_next = S_EXECR;
          OP_I:      state_next = S_EXECI;
          OP_BRANCH: state_next = S_BRANCH;
          OP_JAL:    state_next = S_JAL;
          OP_JALR:   state_next = S_JALR_ADR;
          OP_LUI:    state_next = S_LUI;
          OP_AUIPC:  state_next = S_AUIPC;
          default:   state_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = SRCA_RD1;
        alu_src_b  = SRCB_IMM;
        imm_src    = (op == OP_STORE) ? IMM_S : IMM_I;
        state_next = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req_c = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src  = RES_MEMDATA;
        reg_write_c = 1'b1;
        state_next  = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req_c   = 1'b1;
        mem_write_c = 1'b1;
        adr_src     = 1'b1;
        if (mem_ready) state_next = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a  = SRCA_RD1;
        alu_src_b  = SRCB_RD2;
        alu_op     = ALU_FUNCT;
        state_next = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a  = SRCA_RD1;
        alu_src_b  = SRCB_IMM;
        imm_src    = IMM_I;
        alu_op     = ALU_FUNCT;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        result_src  = RES_ALUOUT;
        reg_write_c = 1'b1;
        state_next  = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = SRCA_RD1;
        alu_src_b  = SRCB_RD2;
        alu_op     = ALU_SUB;
        result_src = RES_ALUOUT;
        pc_write_c = branch_taken;
        state_next = S_FETCH;
      end
      S_JAL: begin
        // PC takes the target held in ALUOut while the ALU forms the link value OldPC + 4.
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALUOUT;
        pc_write_c = 1'b1;
        state_next = S_ALUWB;
      end
      S_JALR_ADR: begin
        alu_src_a  = SRCA_RD1;
        alu_src_b  = SRCB_IMM;
        imm_src    = IMM_I;
        alu_op     = ALU_ADD;
        state_next = S_JAL;
      end
      S_LUI: begin
        imm_src     = IMM_U;
        result_src  = RES_IMMEXT;
        reg_write_c = 1'b1;
        state_next  = S_FETCH;
      end
      S_AUIPC: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_IMM;
        imm_src    = IMM_U;
        alu_op     = ALU_ADD;
        state_next = S_ALUWB;
      end
      S_ILLEGAL: begin
        illegal_c  = 1'b1;
        state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
  end

  // Strobes are held low for the whole reset, including the FETCH state reset forces.
  assign mem_req   = mem_req_c   & rst_n;
  assign mem_write = mem_write_c & rst_n;
  assign ir_write  = ir_write_c  & rst_n;
  assign pc_write  = pc_write_c  & rst_n;
  assign reg_write = reg_write_c & rst_n;
  assign illegal   = illegal_c   & rst_n;

`ifdef MC_CTRL_PERF_EN
  logic instret_inc, stall_inc;

  assign instret_inc = (state_next == S_FETCH) && (state != S_FETCH) && (state != S_ILLEGAL);
  assign stall_inc   = mem_req_c && !mem_ready;

  mc_perf_cnt #(
    .CNT_W(CNT_W)
  ) u_perf_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .instret_inc (instret_inc),
    .stall_inc   (stall_inc),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt),
    .stall_cnt   (stall_cnt)
  );
`endif

endmodule
